// File: rtl/dac_arbiter.sv
// rtl/dac_arbiter.sv - DAC SPI sequencer: control-register init, loop/host arbitration, two-frame readback
module dac_arbiter #(
    parameter int                  WID       = 24,
    parameter int                  DATA_WID  = 20,
    parameter logic [DATA_WID-1:0] CTRL_INIT = '0,
    parameter bit                  INIT_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_L,
    input  logic                loop_arm,
    input  logic [DATA_WID-1:0] loop_val,
    output logic                loop_fin,
    input  logic                host_arm,
    input  logic [WID-1:0]      host_cmd,
    output logic                host_fin,
    output logic [WID-1:0]      host_resp,
    output logic                host_err,
    output logic                init_done,
    output logic                spi_arm,
    output logic [WID-1:0]      spi_to_slave,
    input  logic [WID-1:0]      spi_from_slave,
    input  logic                spi_finished
);

    typedef enum logic [3:0] {
        INIT_ARM, INIT_WAIT, INIT_REL, IDLE, ARM, WAIT, REL, RD2_ARM, RD2_WAIT, RD2_REL
    } state_t;

    localparam logic [3:0] OP_LOOP = 4'b0001;
    localparam logic [3:0] OP_CTRL = 4'b0010;

    state_t     state;
    logic       fair;
    logic       own_host;
    logic       own_read;
    logic [3:0] cmd_hdr;

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state        <= INIT_EN ? INIT_ARM : IDLE;
            fair         <= 1'b0;
            own_host     <= 1'b0;
            own_read     <= 1'b0;
            cmd_hdr      <= '0;
            loop_fin     <= 1'b0;
            host_fin     <= 1'b0;
            host_resp    <= '0;
            host_err     <= 1'b0;
            init_done    <= 1'b0;
            spi_arm      <= 1'b0;
            spi_to_slave <= '0;
        end else begin
            loop_fin <= 1'b0;
            host_fin <= 1'b0;
            case (state)
                INIT_ARM: begin
                    spi_to_slave <= {OP_CTRL, CTRL_INIT};
                    spi_arm      <= 1'b1;
                    state        <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (spi_finished) begin
                        spi_arm <= 1'b0;
                        state   <= INIT_REL;
                    end
                end
                INIT_REL: begin
                    if (!spi_finished) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    // Also covers the no-init configuration, which enters IDLE directly.
                    init_done <= 1'b1;
                    if (host_arm && (fair || !loop_arm)) begin
                        own_host     <= 1'b1;
                        own_read     <= host_cmd[WID-1];
                        cmd_hdr      <= host_cmd[WID-1:WID-4];
                        host_err     <= 1'b0;
                        fair         <= 1'b0;
                        spi_to_slave <= host_cmd;
                        spi_arm      <= 1'b1;
                        state        <= ARM;
                    end else if (loop_arm) begin
                        own_host     <= 1'b0;
                        own_read     <= 1'b0;
                        fair         <= 1'b1;
                        spi_to_slave <= {OP_LOOP, loop_val};
                        spi_arm      <= 1'b1;
                        state        <= ARM;
                    end
                end
                ARM, WAIT: begin
                    if (spi_finished) begin
                        spi_arm <= 1'b0;
                        state   <= REL;
                        if (!own_host) begin
                            loop_fin <= 1'b1;
                        end else if (!own_read) begin
                            host_fin  <= 1'b1;
                            host_resp <= '0;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                REL: begin
                    // A read keeps ownership straight into the NOP frame, so nothing can slip in between.
                    if (!spi_finished) state <= own_read ? RD2_ARM : IDLE;
                end
                RD2_ARM: begin
                    spi_to_slave <= '0;
                    spi_arm      <= 1'b1;
                    state        <= RD2_WAIT;
                end
                RD2_WAIT: begin
                    if (spi_finished) begin
                        spi_arm   <= 1'b0;
                        host_resp <= spi_from_slave;
                        host_err  <= (spi_from_slave[WID-1:WID-4] != cmd_hdr);
                        host_fin  <= 1'b1;
                        state     <= RD2_REL;
                    end
                end
                RD2_REL: begin
                    if (!spi_finished) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_arbiter.sv
// tb/tb_dac_arbiter.sv - directed self-checking bench for dac_arbiter with a behavioural SPI slave
module tb_dac_arbiter;
    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        loop_arm = 1'b0;
    logic [19:0] loop_val = '0;
    logic        loop_fin;
    logic        host_arm = 1'b0;
    logic [23:0] host_cmd = '0;
    logic        host_fin;
    logic [23:0] host_resp;
    logic        host_err;
    logic        init_done;
    logic        spi_arm;
    logic [23:0] spi_to_slave;
    logic [23:0] spi_from_slave = '0;
    logic        spi_finished = 1'b0;
    logic [23:0] model_resp = '0;

    always #5 clk = ~clk;

    dac_arbiter #(.WID(24), .DATA_WID(20), .CTRL_INIT(20'h00012), .INIT_EN(1'b1)) dut (
        .clk(clk), .rst_L(rst_L),
        .loop_arm(loop_arm), .loop_val(loop_val), .loop_fin(loop_fin),
        .host_arm(host_arm), .host_cmd(host_cmd), .host_fin(host_fin),
        .host_resp(host_resp), .host_err(host_err), .init_done(init_done),
        .spi_arm(spi_arm), .spi_to_slave(spi_to_slave),
        .spi_from_slave(spi_from_slave), .spi_finished(spi_finished)
    );

    // SPI master/slave model: transfer takes 4 cycles; a NOP frame returns model_resp, anything else junk.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (!spi_arm) begin
            spi_finished <= 1'b0;
            busy_cnt     <= 0;
        end else if (!spi_finished) begin
            if (busy_cnt == 3) begin
                spi_finished   <= 1'b1;
                spi_from_slave <= (spi_to_slave == 24'h0) ? model_resp : 24'h5A5A5A;
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
        end
    end

    logic [23:0] frames[$];
    int          fin_log[$];
    logic        arm_q = 1'b0, fin_l_q = 1'b0, fin_h_q = 1'b0;
    logic [23:0] tx_q = '0;
    int          ov_cnt = 0;
    int          n_overlap = 0, n_wide = 0, n_unstable = 0, n_baddrop = 0;

    always @(negedge clk) begin
        if (spi_arm && !arm_q) begin
            frames.push_back(spi_to_slave);
            ov_cnt <= 0;
        end else if (spi_arm && spi_finished) begin
            ov_cnt <= ov_cnt + 1;
        end
        if (spi_arm && arm_q && spi_to_slave != tx_q) n_unstable <= n_unstable + 1;
        if (!spi_arm && arm_q && rst_L && ov_cnt != 1) n_baddrop <= n_baddrop + 1;
        if (loop_fin && host_fin) n_overlap <= n_overlap + 1;
        if ((loop_fin && fin_l_q) || (host_fin && fin_h_q)) n_wide <= n_wide + 1;
        if (loop_fin && !fin_l_q) fin_log.push_back(0);
        if (host_fin && !fin_h_q) fin_log.push_back(1);
        arm_q   <= spi_arm;
        tx_q    <= spi_to_slave;
        fin_l_q <= loop_fin;
        fin_h_q <= host_fin;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fin(input bit host, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (host ? host_fin : loop_fin) break;
        end
        chk(name, host ? host_fin : loop_fin, 1);
    endtask

    task automatic wait_init(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        chk(name, init_done, 1);
    endtask

    task automatic settle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!spi_arm && !spi_finished) break;
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        bit          host;
        logic [23:0] data;
        logic [23:0] mresp;
        int          nfr;
        logic [23:0] f0;
        logic [23:0] resp;
        bit          err;
    } vec_t;

    vec_t v[6];

    initial begin
        int nf;
        v[0] = '{1'b0, 24'h0ABCDE, 24'h000000, 1, 24'h1ABCDE, 24'h000000, 1'b0};
        v[1] = '{1'b1, 24'h900000, 24'h9ABCDE, 2, 24'h900000, 24'h9ABCDE, 1'b0};
        v[2] = '{1'b1, 24'hA00000, 24'h000000, 2, 24'hA00000, 24'h000000, 1'b1};
        v[3] = '{1'b1, 24'h312345, 24'hFFFFFF, 1, 24'h312345, 24'h000000, 1'b0};
        v[4] = '{1'b0, 24'h000001, 24'h000000, 1, 24'h100001, 24'h000000, 1'b0};
        v[5] = '{1'b1, 24'h8FFFFF, 24'h812345, 2, 24'h8FFFFF, 24'h812345, 1'b0};

        // Reset and init, with a loop request held throughout.
        loop_val = 20'h11111;
        loop_arm = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst spi_arm", spi_arm, 0);
        chk("rst init_done", init_done, 0);
        chk("rst host_resp", host_resp, 0);
        chk("rst fins", {loop_fin, host_fin}, 0);
        chk("rst host_err", host_err, 0);
        rst_L = 1'b1;
        wait_init("init done");
        chk("init fin low", spi_finished, 0);
        chk("init frames", frames.size(), 1);
        chk("init frame", frames.size() > 0 ? frames[0] : 24'hx, 24'h200012);
        chk("init no fin", fin_log.size(), 0);
        wait_fin(0, "held loop fin");
        loop_arm = 1'b0;
        settle();
        chk("held loop frames", frames.size(), 2);
        chk("held loop frame", frames.size() > 1 ? frames[1] : 24'hx, 24'h111111);

        // Host read with a loop request raised between the two frames.
        frames.delete();
        fin_log.delete();
        model_resp = 24'h9ABCDE;
        host_cmd   = 24'h900000;
        host_arm   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frames.size() == 1 && !spi_arm) break;
        end
        chk("rd gap reached", frames.size(), 1);
        loop_val = 20'h22222;
        loop_arm = 1'b1;
        wait_fin(1, "rd host fin");
        chk("rd resp", host_resp, 24'h9ABCDE);
        chk("rd err", host_err, 0);
        host_arm = 1'b0;
        wait_fin(0, "rd loop fin");
        loop_arm = 1'b0;
        settle();
        chk("rd fin count", fin_log.size(), 2);
        chk("rd fin0 host", fin_log.size() > 0 ? fin_log[0] : -1, 1);
        chk("rd fin1 loop", fin_log.size() > 1 ? fin_log[1] : -1, 0);
        chk("rd frames", frames.size(), 3);
        chk("rd frame2 nop", frames.size() > 1 ? frames[1] : 24'hx, 24'h000000);
        chk("rd frame3 loop", frames.size() > 2 ? frames[2] : 24'hx, 24'h122222);

        // Table of single transactions.
        for (int k = 0; k < 6; k++) begin
            frames.delete();
            fin_log.delete();
            model_resp = v[k].mresp;
            if (v[k].host) begin
                host_cmd = v[k].data;
                host_arm = 1'b1;
            end else begin
                loop_val = v[k].data[19:0];
                loop_arm = 1'b1;
            end
            wait_fin(v[k].host, $sformatf("v%0d fin", k));
            if (v[k].host) begin
                chk($sformatf("v%0d resp", k), host_resp, v[k].resp);
                chk($sformatf("v%0d err", k), host_err, v[k].err);
            end
            host_arm = 1'b0;
            loop_arm = 1'b0;
            settle();
            chk($sformatf("v%0d nframes", k), frames.size(), v[k].nfr);
            chk($sformatf("v%0d frame0", k), frames.size() > 0 ? frames[0] : 24'hx, v[k].f0);
            if (v[k].nfr == 2 && frames.size() > 1)
                chk($sformatf("v%0d frame1", k), frames[1], 24'h000000);
            chk($sformatf("v%0d fins", k), fin_log.size(), 1);
            chk($sformatf("v%0d fin who", k), fin_log.size() > 0 ? fin_log[0] : -1, v[k].host);
            if (v[k].host) chk($sformatf("v%0d err sticky", k), host_err, v[k].err);
        end

        // Both requesters held: grants alternate starting with the loop.
        frames.delete();
        fin_log.delete();
        model_resp = 24'h000000;
        loop_val   = 20'h33333;
        host_cmd   = 24'h345678;
        loop_arm   = 1'b1;
        host_arm   = 1'b1;
        nf = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (loop_fin || host_fin) nf++;
            if (nf == 6) break;
        end
        loop_arm = 1'b0;
        host_arm = 1'b0;
        settle();
        chk("alt fins seen", nf, 6);
        chk("alt fin count", fin_log.size(), 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("alt order %0d", j), fin_log.size() > j ? fin_log[j] : -1, j % 2);

        // Reset while a transfer is in flight.
        frames.delete();
        fin_log.delete();
        host_cmd = 24'h312345;
        host_arm = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_arm) break;
        end
        @(negedge clk);
        chk("mid armed", spi_arm, 1);
        rst_L    = 1'b0;
        host_arm = 1'b0;
        @(negedge clk);
        chk("mid arm drop", spi_arm, 0);
        chk("mid init_done", init_done, 0);
        @(negedge clk);
        rst_L = 1'b1;
        wait_init("mid reinit");
        chk("mid no fin", fin_log.size(), 0);
        chk("mid frames", frames.size(), 2);
        chk("mid init frame", frames.size() > 1 ? frames[1] : 24'hx, 24'h200012);

        settle();
        chk("fins overlap", n_overlap, 0);
        chk("fin width", n_wide, 0);
        chk("frame stable", n_unstable, 0);
        chk("arm drop timing", n_baddrop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
